// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_lite_pkg: response codes, master FSM states, word stride.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned ADDR_STRIDE = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_READ    = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } axi_state_t;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_valid_hold.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_lite_valid_hold: VALID held from set until READY is seen.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_lite_valid_hold (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic ready,
   output logic valid,
   output logic done
);

   logic r_valid;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_valid <= 1'b0;
      else if (r_valid && ready)
         r_valid <= 1'b0;
      else if (set)
         r_valid <= 1'b1;
   end

   assign valid = r_valid;
   assign done  = r_valid & ready;

endmodule
`default_nettype wire

// File: rtl/axi_lite_selftest_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_lite_selftest_master: writes seed+i to base+4*i, reads each  |
// | word back and flags any data or response error. Rev 1.0          |
// +------------------------------------------------------------------+
module axi_lite_selftest_master
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
   parameter int          C_M_AXI_ADDR_WIDTH         = 32,
   parameter int          C_M_AXI_DATA_WIDTH         = 32,
   parameter int          C_M_TRANSACTIONS_NUM       = 4,
   parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            INIT_AXI_TXN,
   output logic                            TXN_DONE,
   output logic                            ERROR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int             c_AW       = C_M_AXI_ADDR_WIDTH;
   localparam int             c_DW       = C_M_AXI_DATA_WIDTH;
   localparam logic [8:0]     c_LAST_IDX = 9'(C_M_TRANSACTIONS_NUM - 1);
   localparam logic [c_AW-1:0] c_BASE    = c_AW'(C_M_TARGET_SLAVE_BASE_ADDR);
   localparam logic [c_AW-1:0] c_STRIDE  = c_AW'(ADDR_STRIDE);
   localparam logic [c_DW-1:0] c_SEED    = c_DW'(C_M_START_DATA_VALUE);

   axi_state_t      r_state, w_state_next;
   logic            r_init_ff1, r_init_ff2, w_start;
   logic [8:0]      r_widx, r_ridx;
   logic            r_issue, r_err_latch, r_txn_done, r_error;
   logic            r_aw_acc, r_w_acc, r_ar_acc;
   logic [c_AW-1:0] r_awaddr, r_araddr;
   logic [c_DW-1:0] r_wdata;
   logic            w_aw_set, w_ar_set, w_bready, w_rready;
   logic            w_aw_done, w_w_done, w_ar_done;
   logic            w_b_hs, w_r_hs, w_b_err, w_r_err;
   logic [c_DW-1:0] w_rd_exp;

   assign w_start  = r_init_ff1 & ~r_init_ff2;
   assign w_b_hs   = M_AXI_BVALID & w_bready;
   assign w_r_hs   = M_AXI_RVALID & w_rready;
   assign w_rd_exp = c_SEED + c_DW'(r_ridx);

   // A response arriving before its own address/data handshakes is treated as a failure too.
   assign w_b_err = resp_is_err(M_AXI_BRESP) | ~(r_aw_acc & r_w_acc);
   assign w_r_err = resp_is_err(M_AXI_RRESP) | (M_AXI_RDATA != w_rd_exp) | ~r_ar_acc;

   always_ff @(posedge ACLK) begin
      if (!ARESETN)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_aw_set     = 1'b0;
      w_ar_set     = 1'b0;
      w_bready     = 1'b0;
      w_rready     = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start)
               w_state_next = ST_WRITE;
         end
         ST_WRITE: begin
            w_bready = 1'b1;
            w_aw_set = r_issue;
            if (M_AXI_BVALID && r_widx == c_LAST_IDX)
               w_state_next = ST_READ;
         end
         ST_READ: begin
            w_rready = 1'b1;
            w_ar_set = r_issue;
            if (M_AXI_RVALID && r_ridx == c_LAST_IDX)
               w_state_next = ST_COMPARE;
         end
         ST_COMPARE: w_state_next = ST_DONE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_init_ff1  <= 1'b0;
         r_init_ff2  <= 1'b0;
         r_widx      <= '0;
         r_ridx      <= '0;
         r_issue     <= 1'b0;
         r_err_latch <= 1'b0;
         r_txn_done  <= 1'b0;
         r_error     <= 1'b0;
         r_aw_acc    <= 1'b0;
         r_w_acc     <= 1'b0;
         r_ar_acc    <= 1'b0;
         r_awaddr    <= '0;
         r_araddr    <= '0;
         r_wdata     <= '0;
      end else begin
         r_init_ff1 <= INIT_AXI_TXN;
         r_init_ff2 <= r_init_ff1;
         if (w_aw_set) begin
            r_awaddr <= c_BASE + c_AW'(r_widx) * c_STRIDE;
            r_wdata  <= c_SEED + c_DW'(r_widx);
            r_aw_acc <= 1'b0;
            r_w_acc  <= 1'b0;
            r_issue  <= 1'b0;
         end
         if (w_ar_set) begin
            r_araddr <= c_BASE + c_AW'(r_ridx) * c_STRIDE;
            r_ar_acc <= 1'b0;
            r_issue  <= 1'b0;
         end
         if (w_aw_done) r_aw_acc <= 1'b1;
         if (w_w_done)  r_w_acc  <= 1'b1;
         if (w_ar_done) r_ar_acc <= 1'b1;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  r_txn_done  <= 1'b0;
                  r_error     <= 1'b0;
                  r_err_latch <= 1'b0;
                  r_widx      <= '0;
                  r_ridx      <= '0;
                  r_issue     <= 1'b1;
               end
            end
            ST_WRITE: begin
               // Every B handshake re-arms issue: the next write, or the first read.
               if (w_b_hs) begin
                  if (w_b_err) r_err_latch <= 1'b1;
                  r_widx  <= r_widx + 9'd1;
                  r_issue <= 1'b1;
               end
            end
            ST_READ: begin
               if (w_r_hs) begin
                  if (w_r_err) r_err_latch <= 1'b1;
                  r_ridx <= r_ridx + 9'd1;
                  if (r_ridx != c_LAST_IDX) r_issue <= 1'b1;
               end
            end
            ST_COMPARE: begin
               r_error    <= r_err_latch;
               r_txn_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   axi_lite_valid_hold u_aw_hold (
      .clk(ACLK), .rst_n(ARESETN), .set(w_aw_set), .ready(M_AXI_AWREADY),
      .valid(M_AXI_AWVALID), .done(w_aw_done)
   );

   axi_lite_valid_hold u_w_hold (
      .clk(ACLK), .rst_n(ARESETN), .set(w_aw_set), .ready(M_AXI_WREADY),
      .valid(M_AXI_WVALID), .done(w_w_done)
   );

   axi_lite_valid_hold u_ar_hold (
      .clk(ACLK), .rst_n(ARESETN), .set(w_ar_set), .ready(M_AXI_ARREADY),
      .valid(M_AXI_ARVALID), .done(w_ar_done)
   );

   assign TXN_DONE     = r_txn_done;
   assign ERROR        = r_error;
   assign M_AXI_AWADDR = r_awaddr;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_WDATA  = r_wdata;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_BREADY = w_bready;
   assign M_AXI_ARADDR = r_araddr;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_RREADY = w_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_selftest_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_lite_selftest_master: random-latency slave with fault     |
// | injection, checked against a transaction-level model. Rev 1.0    |
// +------------------------------------------------------------------+
module tb_axi_lite_selftest_master;

   localparam logic [31:0] c_BASE   = 32'h4000_0000;
   localparam logic [31:0] c_SEED   = 32'hAA00_0000;
   localparam int          c_NUM    = 4;
   localparam int          c_BUDGET = 2000;

   logic        tb_ACLK = 1'b0;
   logic        ARESETN = 1'b0, INIT_AXI_TXN = 1'b0;
   logic        TXN_DONE, ERROR;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
   logic [31:0] M_AXI_RDATA = '0;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY;
   logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
   logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
   logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;

   always #5 tb_ACLK = ~tb_ACLK;

   axi_lite_selftest_master #(
      .C_M_TARGET_SLAVE_BASE_ADDR(c_BASE), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
      .C_M_TRANSACTIONS_NUM(c_NUM), .C_M_START_DATA_VALUE(c_SEED)
   ) dut (
      .ACLK(tb_ACLK), .ARESETN(ARESETN), .INIT_AXI_TXN(INIT_AXI_TXN),
      .TXN_DONE(TXN_DONE), .ERROR(ERROR),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Slave configuration and fault injection (-1 = no fault)
   int          cfg_aw_max, cfg_w_max, cfg_ar_max;
   bit          cfg_fixed;
   int          cfg_corrupt_idx, cfg_bresp_idx, cfg_rresp_idx;
   logic [31:0] cfg_corrupt_val;
   logic [1:0]  cfg_bresp_code, cfg_rresp_code;

   // Slave state and transaction logs
   logic [31:0] mem [logic [31:0]];
   logic [31:0] log_aw[$], log_w[$], log_ar[$];
   int          n_b, n_r, n_done_rise, n_viol;
   bit          aw_have, w_have, ar_have;
   logic [31:0] aw_q, w_q, ar_q;
   int          aw_cnt, w_cnt, ar_cnt, aw_wait, w_wait, ar_wait;
   bit          p_awvalid, p_wvalid, p_arvalid, p_aw_hs, p_w_hs, p_ar_hs, p_b_hs, p_r_hs, p_done;
   logic [31:0] p_awaddr, p_wdata, p_araddr;

   function automatic int draw(input int mx);
      return cfg_fixed ? mx : int'($urandom_range(mx, 0));
   endfunction

   function automatic logic [1:0] ok_resp();
      return ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b01;
   endfunction

   // Values seen at a negedge are exactly what the following posedge samples.
   task automatic slave_step();
      if (!ARESETN) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
         M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
         aw_have = 0; w_have = 0; ar_have = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
         p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_done = 0;
         p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_b_hs = 0; p_r_hs = 0;
         return;
      end
      if (p_aw_hs) begin aw_have = 1; aw_q = p_awaddr; log_aw.push_back(p_awaddr); aw_cnt = 0; aw_wait = draw(cfg_aw_max); end
      if (p_w_hs)  begin w_have = 1; w_q = p_wdata; log_w.push_back(p_wdata); w_cnt = 0; w_wait = draw(cfg_w_max); end
      if (p_ar_hs) begin ar_have = 1; ar_q = p_araddr; log_ar.push_back(p_araddr); ar_cnt = 0; ar_wait = draw(cfg_ar_max); end
      if (p_b_hs) begin M_AXI_BVALID = 0; n_b++; end
      if (p_r_hs) begin M_AXI_RVALID = 0; n_r++; end

      if ($isunknown({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY})) n_viol++;
      if (p_awvalid && !p_aw_hs && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) n_viol++;
      if (p_wvalid && !p_w_hs && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata)) n_viol++;
      if (p_arvalid && !p_ar_hs && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)) n_viol++;
      if ((p_aw_hs && M_AXI_AWVALID) || (p_w_hs && M_AXI_WVALID) || (p_ar_hs && M_AXI_ARVALID)) n_viol++;
      if ((!p_awvalid && M_AXI_AWVALID) != (!p_wvalid && M_AXI_WVALID)) n_viol++;
      if (!p_awvalid && M_AXI_AWVALID && log_aw.size() != n_b) n_viol++;
      if (!p_arvalid && M_AXI_ARVALID && log_ar.size() != n_r) n_viol++;

      if (aw_have && w_have && !M_AXI_BVALID) begin
         mem[aw_q] = w_q;
         M_AXI_BRESP = (n_b == cfg_bresp_idx) ? cfg_bresp_code : ok_resp();
         M_AXI_BVALID = 1; aw_have = 0; w_have = 0;
      end
      if (ar_have && !M_AXI_RVALID) begin
         M_AXI_RDATA = mem.exists(ar_q) ? mem[ar_q] : 32'h0;
         if (n_r == cfg_corrupt_idx) M_AXI_RDATA = cfg_corrupt_val;
         M_AXI_RRESP = (n_r == cfg_rresp_idx) ? cfg_rresp_code : ok_resp();
         M_AXI_RVALID = 1; ar_have = 0;
      end

      M_AXI_AWREADY = 0;
      if (M_AXI_AWVALID && !aw_have) begin
         if (aw_cnt >= aw_wait) M_AXI_AWREADY = 1; else aw_cnt++;
      end
      M_AXI_WREADY = 0;
      if (M_AXI_WVALID && !w_have) begin
         if (w_cnt >= w_wait) M_AXI_WREADY = 1; else w_cnt++;
      end
      M_AXI_ARREADY = 0;
      if (M_AXI_ARVALID && !ar_have) begin
         if (ar_cnt >= ar_wait) M_AXI_ARREADY = 1; else ar_cnt++;
      end

      p_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY; p_awvalid = M_AXI_AWVALID; p_awaddr = M_AXI_AWADDR;
      p_w_hs  = M_AXI_WVALID & M_AXI_WREADY;   p_wvalid  = M_AXI_WVALID;  p_wdata  = M_AXI_WDATA;
      p_ar_hs = M_AXI_ARVALID & M_AXI_ARREADY; p_arvalid = M_AXI_ARVALID; p_araddr = M_AXI_ARADDR;
      p_b_hs  = M_AXI_BVALID & M_AXI_BREADY;
      p_r_hs  = M_AXI_RVALID & M_AXI_RREADY;
      if (TXN_DONE && !p_done) n_done_rise++;
      p_done = TXN_DONE;
   endtask

   task automatic tick();
      @(negedge tb_ACLK);
      slave_step();
   endtask

   task automatic set_cfg(input int aw_max, input int w_max, input int ar_max, input bit fixed);
      cfg_aw_max = aw_max; cfg_w_max = w_max; cfg_ar_max = ar_max; cfg_fixed = fixed;
      cfg_corrupt_idx = -1; cfg_bresp_idx = -1; cfg_rresp_idx = -1;
      cfg_corrupt_val = '0; cfg_bresp_code = 2'b10; cfg_rresp_code = 2'b10;
      aw_wait = draw(aw_max); w_wait = draw(w_max); ar_wait = draw(ar_max);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ctl"}, 64'({TXN_DONE, ERROR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                              M_AXI_ARVALID, M_AXI_RREADY}), 64'h0);
      chk({tag, "_awaddr"}, 64'(M_AXI_AWADDR), 64'h0);
      chk({tag, "_wdata"}, 64'(M_AXI_WDATA), 64'h0);
      chk({tag, "_araddr"}, 64'(M_AXI_ARADDR), 64'h0);
   endtask

   task automatic run_seq(input bit mid_pulse, input bit rst_aw2);
      bit exp_err;
      int cyc, pulse_cnt;
      bit pulsed;
      exp_err = (cfg_corrupt_idx >= 0) || (cfg_bresp_idx >= 0) || (cfg_rresp_idx >= 0);
      log_aw.delete(); log_w.delete(); log_ar.delete();
      n_b = 0; n_r = 0; n_done_rise = 0; n_viol = 0;
      INIT_AXI_TXN = 1; tick(); tick(); INIT_AXI_TXN = 0;
      pulsed = 0; pulse_cnt = 0; cyc = 0;
      while (n_done_rise == 0 && cyc < c_BUDGET) begin
         tick(); cyc++;
         if (mid_pulse && !pulsed && log_ar.size() >= 1) begin
            INIT_AXI_TXN = 1; pulsed = 1; pulse_cnt = 2;
         end else if (pulse_cnt > 0) begin
            pulse_cnt--;
            if (pulse_cnt == 0) INIT_AXI_TXN = 0;
         end
         if (rst_aw2 && log_aw.size() == 2) begin
            ARESETN = 0; tick();
            check_reset("midrst");
            ARESETN = 1; tick();
            return;
         end
      end
      chk("done_in_budget", 64'(n_done_rise != 0), 64'h1);
      repeat (10) tick();
      chk("aw_count", 64'(log_aw.size()), 64'(c_NUM));
      chk("ar_count", 64'(log_ar.size()), 64'(c_NUM));
      for (int i = 0; i < c_NUM; i++) begin
         chk($sformatf("awaddr[%0d]", i), (i < log_aw.size()) ? 64'(log_aw[i]) : 64'hx, 64'(c_BASE + 32'(4 * i)));
         chk($sformatf("wdata[%0d]", i),  (i < log_w.size())  ? 64'(log_w[i])  : 64'hx, 64'(c_SEED + 32'(i)));
         chk($sformatf("araddr[%0d]", i), (i < log_ar.size()) ? 64'(log_ar[i]) : 64'hx, 64'(c_BASE + 32'(4 * i)));
      end
      chk("b_count", 64'(n_b), 64'(c_NUM));
      chk("r_count", 64'(n_r), 64'(c_NUM));
      chk("done_rises", 64'(n_done_rise), 64'h1);
      chk("TXN_DONE", 64'(TXN_DONE), 64'h1);
      chk("ERROR", 64'(ERROR), 64'(exp_err));
      chk("protocol", 64'(n_viol), 64'h0);
   endtask

   initial begin
      int sel, idx;
      set_cfg(0, 0, 0, 1'b1);
      ARESETN = 0;
      repeat (3) tick();
      check_reset("por");
      ARESETN = 1;
      repeat (2) tick();

      set_cfg(0, 0, 0, 1'b1); run_seq(0, 0);
      set_cfg(0, 3, 0, 1'b1); run_seq(0, 0);
      set_cfg(0, 0, 0, 1'b1); cfg_corrupt_idx = 2; cfg_corrupt_val = 32'hDEAD_0011; run_seq(0, 0);
      set_cfg(0, 0, 0, 1'b1); cfg_bresp_idx = 1; cfg_bresp_code = 2'b10; run_seq(0, 0);
      set_cfg(0, 0, 0, 1'b1); run_seq(0, 0);
      set_cfg(0, 0, 0, 1'b1); run_seq(1, 0);
      set_cfg(0, 0, 0, 1'b1); run_seq(0, 1);
      set_cfg(0, 0, 0, 1'b1); run_seq(0, 0);

      for (int k = 0; k < 8; k++) begin
         set_cfg(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0);
         sel = int'($urandom_range(3, 0));
         idx = int'($urandom_range(c_NUM - 1, 0));
         case (sel)
            0: begin cfg_corrupt_idx = idx; cfg_corrupt_val = (c_SEED + 32'(idx)) ^ ($urandom() | 32'h1); end
            1: begin cfg_bresp_idx = idx; cfg_bresp_code = ($urandom_range(1, 0) == 0) ? 2'b10 : 2'b11; end
            2: begin cfg_rresp_idx = idx; cfg_rresp_code = ($urandom_range(1, 0) == 0) ? 2'b10 : 2'b11; end
            default: ;
         endcase
         run_seq(0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
